// File: rtl/ita_activation_drain.sv
// Activation drain: tracks launches through the fixed-latency activation unit, captures outputs
// into a FIFO and issues launch credits. Optional ITA_ACT_DRAIN_OVERFLOW_EN adds a sticky overflow flag.
module ita_activation_drain #(
  parameter int N       = 16,
  parameter int WI      = 8,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_i,
  input  logic                         issue_last_i,
  output logic                         issue_ready_o,
  input  logic [N*WI-1:0]              act_data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [N*WI-1:0]              data_o,
  output logic                         last_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o
);

  localparam int VW = N * WI;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int SW = $clog2(DEPTH + LATENCY + 1);
  localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [LATENCY-1:0] tag_v_q, tag_v_d, tag_l_q, tag_l_d;
  logic [IW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [VW:0]        mem_q [DEPTH];
  logic [VW:0]        head;
  logic [SW-1:0]      credit_sum;
  logic               cap_v, cap_last, full, push, pop;

  always_comb begin
    tag_v_d    = '0;
    tag_l_d    = '0;
    tag_v_d[0] = issue_i;
    tag_l_d[0] = issue_last_i;
    for (int i = 1; i < LATENCY; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_l_d[i] = tag_l_q[i-1];
    end
  end

  assign cap_v    = tag_v_q[LATENCY-1];
  assign cap_last = tag_l_q[LATENCY-1];
  assign valid_o  = (count_q != '0);
  assign full     = (count_q == CNT_FULL);
  assign pop      = valid_o && ready_i;
  // A capture into a full FIFO only lands if the head leaves in the same cycle.
  assign push     = cap_v && (!full || pop);

  always_comb begin
    inflight_d = inflight_q;
    if (issue_i && !cap_v)      inflight_d = inflight_q + IW'(1);
    else if (!issue_i && cap_v) inflight_d = inflight_q - IW'(1);

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);

    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
  end

  // Credit ignores a same-cycle pop so ready_i never reaches issue_ready_o.
  assign credit_sum    = SW'(count_q) + SW'(inflight_q);
  assign issue_ready_o = (credit_sum < SW'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_v_q    <= '0;
      tag_l_q    <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      tag_v_q    <= tag_v_d;
      tag_l_q    <= tag_l_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {cap_last, act_data_i};
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign data_o  = head[VW-1:0];
  assign last_o  = head[VW];
  assign count_o = count_q;

`ifdef ITA_ACT_DRAIN_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                     overflow_q <= 1'b0;
    else if (cap_v && full && !pop) overflow_q <= 1'b1;
  end

  assign overflow_o = overflow_q;

  a_issue_credit: assert property (@(posedge clk_i) disable iff (rst_i)
    !(issue_i && !issue_ready_o));
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_ita_activation_drain.sv
// Scoreboard bench for ita_activation_drain; honours ITA_ACT_DRAIN_OVERFLOW_EN for the overflow flag.
module tb_ita_activation_drain;

  localparam int N  = 16;
  localparam int WI = 8;
  localparam int L  = 4;
  localparam int D  = 8;
  localparam int VW = N * WI;
  localparam int CW = $clog2(D + 1);
  localparam logic [CW-1:0] C_FULL = CW'(D);
  localparam logic [CW-1:0] C_ZERO = CW'(0);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
`ifdef ITA_ACT_DRAIN_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i, issue_i, issue_last_i, issue_ready_o, valid_o, ready_i, last_o, overflow_o;
  logic [VW-1:0] act_data_i, data_o;
  logic [CW-1:0] count_o;

  ita_activation_drain #(.N(N), .WI(WI), .LATENCY(L), .DEPTH(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .issue_i(issue_i), .issue_last_i(issue_last_i),
    .issue_ready_o(issue_ready_o), .act_data_i(act_data_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .last_o(last_o), .count_o(count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;
  int n_pops   = 0;
  int first_pop, last_pop;
  logic [VW:0] sb[$];
  logic [VW:0] mon_exp;
  int mcount;
  bit mv[L];
  bit ml[L];
  logic [VW-1:0] md[L];

  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  // Consumer side: every handshake pops the oldest expected vector.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1) begin
      n_pops++;
      if (n_pops == 1) first_pop = cyc_n;
      last_pop = cyc_n;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_pop: got last=%b data=%h, required no output", last_o, data_o);
      end else begin
        mon_exp = sb.pop_front();
        if ({last_o, data_o} !== mon_exp)
          $display("FAIL sb_data: got last=%b data=%h, required last=%b data=%h",
                   last_o, data_o, mon_exp[VW], mon_exp[VW-1:0]);
        else n_pass++;
      end
    end
  end

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic cyc(input bit iss, input bit lst, input bit rdy, input logic [VW-1:0] vec);
    bit cap, pop, push;
    cap          = mv[L-1];
    issue_i      = iss;
    issue_last_i = lst;
    ready_i      = rdy;
    act_data_i   = cap ? md[L-1] : rnd_vec();
    pop  = (mcount != 0) && rdy;
    push = cap && ((mcount != D) || pop);
    if (push) sb.push_back({ml[L-1], md[L-1]});
    mcount = mcount + int'(push) - int'(pop);
    for (int i = L - 1; i > 0; i--) begin
      mv[i] = mv[i-1];
      ml[i] = ml[i-1];
      md[i] = md[i-1];
    end
    mv[0] = iss;
    ml[0] = lst;
    md[0] = vec;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i        = 1'b1;
    issue_i      = 1'b0;
    issue_last_i = 1'b0;
    ready_i      = 1'b0;
    act_data_i   = rnd_vec();
    @(posedge clk_i);
    #1;
    rst_i  = 1'b0;
    mcount = 0;
    sb.delete();
    for (int i = 0; i < L; i++) begin
      mv[i] = 1'b0;
      ml[i] = 1'b0;
      md[i] = '0;
    end
  endtask

  task automatic fill_full();
    for (int k = 0; k < 20; k++) begin
      if (issue_ready_o) cyc(1'b1, 1'b0, 1'b0, rnd_vec());
      else               cyc(1'b0, 1'b0, 1'b0, rnd_vec());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (valid_o !== 1'b0) $display("FAIL rst_valid: got %b, required 0", valid_o); else n_pass++;
    n_checks++; if (last_o !== 1'b0) $display("FAIL rst_last: got %b, required 0", last_o); else n_pass++;
    n_checks++; if (data_o !== '0) $display("FAIL rst_data: got %h, required 0", data_o); else n_pass++;
    n_checks++; if (count_o !== C_ZERO) $display("FAIL rst_count: got %0d, required 0", count_o); else n_pass++;
    n_checks++; if (issue_ready_o !== 1'b1) $display("FAIL rst_ready: got %b, required 1", issue_ready_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL rst_ovf: got %b, required 0", overflow_o); else n_pass++;
  endtask

  task automatic test_single();
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*WI +: WI] = WI'(i + 1);
    cyc(1'b1, 1'b1, 1'b0, v);
    for (int k = 0; k < L - 1; k++) cyc(1'b0, 1'b0, 1'b0, rnd_vec());
    n_checks++; if (valid_o !== 1'b0) $display("FAIL single_early: got valid %b, required 0", valid_o); else n_pass++;
    cyc(1'b0, 1'b0, 1'b0, rnd_vec());
    n_checks++; if (valid_o !== 1'b1) $display("FAIL single_valid: got %b, required 1", valid_o); else n_pass++;
    n_checks++; if (data_o !== v) $display("FAIL single_data: got %h, required %h", data_o, v); else n_pass++;
    n_checks++; if (last_o !== 1'b1) $display("FAIL single_last: got %b, required 1", last_o); else n_pass++;
    n_checks++; if (count_o !== C_ONE) $display("FAIL single_count: got %0d, required 1", count_o); else n_pass++;
    cyc(1'b0, 1'b0, 1'b1, rnd_vec());
    n_checks++; if (count_o !== C_ZERO) $display("FAIL single_pop: got count %0d, required 0", count_o); else n_pass++;
  endtask

  task automatic test_credit();
    int issued = 0;
    for (int k = 0; k < 20; k++) begin
      if (issue_ready_o) begin
        issued++;
        cyc(1'b1, issued == 8, 1'b0, rnd_vec());
        if (issued == 8) begin
          n_checks++;
          if (issue_ready_o !== 1'b0) $display("FAIL credit_after8: got %b, required 0", issue_ready_o);
          else n_pass++;
        end
      end else begin
        cyc(1'b0, 1'b0, 1'b0, rnd_vec());
      end
    end
    n_checks++; if (issued != D) $display("FAIL credit_issued: got %0d, required %0d", issued, D); else n_pass++;
    n_checks++; if (count_o !== C_FULL) $display("FAIL credit_count: got %0d, required 8", count_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL credit_ovf: got %b, required 0", overflow_o); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    logic [VW-1:0] vnew;
    vnew = rnd_vec();
    cyc(1'b1, 1'b0, 1'b0, vnew);
    for (int k = 0; k < L - 1; k++) cyc(1'b0, 1'b0, 1'b0, rnd_vec());
    cyc(1'b0, 1'b0, 1'b1, rnd_vec());
    n_checks++; if (count_o !== C_FULL) $display("FAIL fpp_count: got %0d, required 8", count_o); else n_pass++;
    for (int k = 0; k < D - 1; k++) cyc(1'b0, 1'b0, 1'b1, rnd_vec());
    n_checks++; if (count_o !== C_ONE) $display("FAIL fpp_tail_count: got %0d, required 1", count_o); else n_pass++;
    n_checks++; if (data_o !== vnew) $display("FAIL fpp_tail_data: got %h, required %h", data_o, vnew); else n_pass++;
    cyc(1'b0, 1'b0, 1'b1, rnd_vec());
    n_checks++; if (count_o !== C_ZERO) $display("FAIL fpp_drain: got %0d, required 0", count_o); else n_pass++;
    n_checks++; if (sb.size() != 0) $display("FAIL fpp_sb_left: got %0d, required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_streaming();
    int drops = 0;
    logic [VW-1:0] v;
    n_pops = 0;
    for (int i = 0; i < 32; i++) begin
      if (issue_ready_o !== 1'b1) drops++;
      v = rnd_vec();
      v[WI-1:0] = i[WI-1:0];
      cyc(1'b1, i == 31, 1'b1, v);
    end
    for (int k = 0; k < L + 4; k++) cyc(1'b0, 1'b0, 1'b1, rnd_vec());
    n_checks++; if (drops != 0) $display("FAIL stream_credit: got %0d drops, required 0", drops); else n_pass++;
    n_checks++; if (n_pops != 32) $display("FAIL stream_pops: got %0d, required 32", n_pops); else n_pass++;
    n_checks++; if (last_pop - first_pop != 31) $display("FAIL stream_gaps: got span %0d, required 31", last_pop - first_pop); else n_pass++;
    n_checks++; if (sb.size() != 0) $display("FAIL stream_sb_left: got %0d, required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_overflow();
    fill_full();
    cyc(1'b1, 1'b0, 1'b0, rnd_vec());
    for (int k = 0; k < L; k++) cyc(1'b0, 1'b0, 1'b0, rnd_vec());
    n_checks++; if (overflow_o !== OVF_EN) $display("FAIL ovf_flag: got %b, required %b", overflow_o, OVF_EN); else n_pass++;
    n_checks++; if (count_o !== C_FULL) $display("FAIL ovf_count: got %0d, required 8", count_o); else n_pass++;
    for (int k = 0; k < D + 2; k++) cyc(1'b0, 1'b0, 1'b1, rnd_vec());
    n_checks++; if (overflow_o !== OVF_EN) $display("FAIL ovf_sticky: got %b, required %b", overflow_o, OVF_EN); else n_pass++;
    n_checks++; if (count_o !== C_ZERO) $display("FAIL ovf_drain: got %0d, required 0", count_o); else n_pass++;
    n_checks++; if (sb.size() != 0) $display("FAIL ovf_sb_left: got %0d, required 0", sb.size()); else n_pass++;
    do_reset();
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL ovf_clear: got %b, required 0", overflow_o); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    bit seen = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, rnd_vec());
    do_reset();
    n_checks++; if (valid_o !== 1'b0) $display("FAIL mid_valid: got %b, required 0", valid_o); else n_pass++;
    n_checks++; if (count_o !== C_ZERO) $display("FAIL mid_count: got %0d, required 0", count_o); else n_pass++;
    n_checks++; if (issue_ready_o !== 1'b1) $display("FAIL mid_ready: got %b, required 1", issue_ready_o); else n_pass++;
    n_checks++; if (data_o !== '0) $display("FAIL mid_data: got %h, required 0", data_o); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 1'b1, rnd_vec());
      if (valid_o !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) $display("FAIL mid_ghost: got valid after reset, required none"); else n_pass++;
    n_checks++; if (count_o !== C_ZERO) $display("FAIL mid_count_end: got %0d, required 0", count_o); else n_pass++;
  endtask

  initial begin
    rst_i        = 1'b1;
    issue_i      = 1'b0;
    issue_last_i = 1'b0;
    ready_i      = 1'b0;
    act_data_i   = '0;
    test_reset();
    test_single();
    test_credit();
    test_full_push_pop();
    test_streaming();
    test_overflow();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
